// File: rtl/serial_tx_arbiter_if.sv
// rtl/serial_tx_arbiter_if.sv - requester handshake and serial_tx strobe bundle for serial_tx_arbiter
// slave: arbiter side; master: requesters plus the serial_tx busy return.
`timescale 1ns/1ps
interface serial_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_lock;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               tx_wr;
  logic [7:0]         tx_data;
  logic               tx_busy;

  modport slave (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, grant, busy, tx_wr, tx_data
  );

  modport master (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, grant, busy, tx_wr, tx_data
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin arbiter sharing one serial_tx among N_REQ byte sources
// Optional grant hold per requester: define SERIAL_TX_ARBITER_LOCK_EN.
`timescale 1ns/1ps
module serial_tx_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  serial_tx_arbiter_if.slave bus
);

  localparam int IDXW = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GUARD,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              lock_hold;
  logic              found;
  logic [IDXW-1:0]   win_idx;
  logic [N_REQ-1:0]  ready_n;
  logic [7:0]        data_sel;

`ifdef SERIAL_TX_ARBITER_LOCK_EN
  assign lock_hold = bus.req_lock[last_q];
`else
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
  assign lock_hold   = 1'b0;
`endif

  // A held lock pins the winner to the last owner, even while it has nothing to send.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    if (lock_hold) begin
      found   = bus.req_valid[last_q];
      win_idx = last_q;
    end else begin
      for (int off = 1; off <= N_REQ; off++) begin
        int cand;
        cand = int'(last_q) + off;
        if (cand >= N_REQ) begin
          cand = cand - N_REQ;
        end
        if (!found && bus.req_valid[cand]) begin
          found   = 1'b1;
          win_idx = cand[IDXW-1:0];
        end
      end
    end
  end

  always_comb begin
    ready_n  = '0;
    data_sel = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if ((state_q == IDLE) && !bus.tx_busy && found && (win_idx == IDXW'(k))) begin
        ready_n[k] = 1'b1;
        data_sel   = bus.req_data[8*k +: 8];
      end
    end
  end

  // GUARD skips one busy sample because serial_tx raises busy a cycle after the strobe.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (|ready_n) begin
          tx_data_d = data_sel;
          grant_d   = ready_n;
          last_d    = win_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = GUARD;
      GUARD: state_d = DRAIN;
      DRAIN: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      last_q    <= IDXW'(N_REQ - 1);
      grant_q   <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.req_ready = ready_n;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.tx_wr     = (state_q == ISSUE);
  assign bus.tx_data   = tx_data_q;

endmodule
